pkt_rr_arbiter: RTL and testbench
=================================

Name: pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_IN Avalon-ST packet streams into one stream feeding a unified_pkt_fifo input.
- The FIFO is configured with USE_ALMOST_FULL=1; this block is the upstream that honours almost_full.
- Once a packet starts, its input stays locked to the output until EOP, so packets are never interleaved.
- Also flags malformed input framing per input.

Parameters:
- NUM_IN, 4: number of requesting input streams (2..16).
- DATA_W, 512: beat data width (SYMBOLS_PER_BEAT*BITS_PER_SYMBOL).
- EMPTY_W, 6: empty field width.
- IDX_W, $clog2(NUM_IN): grant index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*DATA_W  input beats; input i at [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- in_startofpacket  in  NUM_IN  per-input SOP.
- in_endofpacket  in  NUM_IN  per-input EOP.
- in_empty  in  NUM_IN*EMPTY_W  per-input empty.
- out_data  out  DATA_W  merged beat to FIFO in_data.
- out_valid  out  1  to FIFO in_valid.
- out_ready  in  1  from FIFO in_ready.
- out_startofpacket  out  1  merged SOP.
- out_endofpacket  out  1  merged EOP.
- out_empty  out  EMPTY_W  merged empty.
- fifo_almost_full  in  1  from FIFO almost_full (registered in the FIFO).
- busy  out  1  high while locked mid-packet (state LOCKED).
- grant_idx  out  IDX_W  currently selected input; valid when out_valid or busy.
- proto_err  out  NUM_IN  sticky per-input framing error.
- clr_err  in  1  synchronous clear of proto_err.

Behaviour:
- States: IDLE, LOCKED. Registers: state, lock_idx, rr_last (last granted index), proto_err.
- Reset (async, rst_l=0): state=IDLE, lock_idx=0, rr_last=NUM_IN-1 so input 0 has first priority, proto_err=0. All outputs derived from these registers: out_valid=0, in_ready=0, busy=0, grant_idx=0.
- Stall: stall = fifo_almost_full. A beat transfers only when out_valid & out_ready; out_valid is forced 0 while stall=1. The FIFO headroom (FIFO_DEPTH-FULL_LEVEL) absorbs the FIFO's 1-cycle almost_full lag.
- IDLE arbitration (combinational, zero latency):
  - Candidates: in_valid[i] & in_startofpacket[i].
  - Pick the first candidate at rr_last+1, rr_last+2, ... with wrap modulo NUM_IN.
  - If found: grant_idx=pick; out_* = input pick; out_valid = !stall; in_ready[pick] = out_ready & !stall.
- IDLE transfer of the first beat:
  - rr_last <= pick.
  - If the beat has EOP: stay IDLE (single-beat packet; back-to-back single-beat packets sustain 1 beat/cycle).
  - Otherwise: lock_idx <= pick, state <= LOCKED.
- IDLE misaligned input: in_valid[i] & !in_startofpacket[i] is a stray beat. in_ready[i]=1 regardless of stall, beat is discarded, proto_err[i] <= 1. Flushing does not block arbitration of other inputs in the same cycle.
- LOCKED:
  - grant_idx=lock_idx; out_* = input lock_idx; out_valid = in_valid[lock_idx] & !stall; in_ready[lock_idx] = out_ready & !stall; all other in_ready=0.
  - Transfer with EOP: state <= IDLE. rr_last is unchanged (already set at SOP).
  - Locked input presents SOP before EOP: the beat is still forwarded, proto_err[lock_idx] <= 1, and the lock is held until an EOP.
  - Idle bubbles (in_valid low) on the locked input do not release the lock.
- proto_err: sticky. clr_err clears it. If clr_err and a new error occur in the same cycle, the set wins.
- Outputs are combinational from registered state plus inputs (no pipeline register). The FIFO's registered input absorbs the timing.
- Reset mid-packet: the lock is dropped and the FIFO is expected to be reset together with this block. Partial packets are the system's concern, not this block's.

Optional Feature:
- Macro: PKT_ARB_STATS_EN.
- Defined: adds output pkt_cnt [NUM_IN*32] (per-input packets granted, incremented on each EOP transfer) and stall_cnt [32] (cycles with a grant pending and stall=1). All counters wrap at 2^32 and are reset by rst_l.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package pkt_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - localparam EMPTY_W_DEF=6;
  - function rr_next(valid vector, last index) returning {found, index}.
- Sub-module pkt_rr_picker: combinational rotating priority encoder (req[NUM_IN], last[IDX_W] -> gnt_vld, gnt_idx). Instantiated once.

Test Plan:
- Inputs 0 and 2 each hold a 3-beat packet, out_ready=1 -> output: 0,0,0,2,2,2 with no interleave; grant_idx 0 then 2; rr_last=2 afterwards.
- All 4 inputs stream continuous 1-beat packets -> grant order 0,1,2,3,0,... at 1 beat/cycle; out_valid never drops.
- fifo_almost_full=1 for 5 cycles mid-packet on input 1 -> out_valid=0 and in_ready[1]=0 for those 5 cycles; packet resumes intact, busy held.
- Input 3 sends a beat with valid=1, SOP=0 while IDLE -> beat consumed (in_ready[3]=1), not on output, proto_err=4'b1000; clr_err pulse -> 4'b0000.
- Assert rst_l=0 while locked on input 2 mid-packet -> asynchronously out_valid=0, busy=0, all in_ready=0; after release, input 0 wins the first arbitration.
- With PKT_ARB_STATS_EN defined: 10 packets on input 1 -> pkt_cnt[1]=10, others 0.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// Shared types, defaults and the rotating-priority search used by pkt_rr_arbiter.
package pkt_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  localparam int EMPTY_W_DEF = 6;
  localparam int MAX_IN      = 16;
  localparam int MAX_IDX_W   = 4;

  // Returns {found, index}: first set bit of req after 'last', wrapping modulo n.
  function automatic logic [MAX_IDX_W:0] rr_next(input logic [MAX_IN-1:0]    req,
                                                 input logic [MAX_IDX_W-1:0] last,
                                                 input int                   n);
    logic [MAX_IDX_W:0] res;
    int                 idx;
    res = '0;
    for (int k = 1; k <= MAX_IN; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !res[MAX_IDX_W] && req[idx[MAX_IDX_W-1:0]]) begin
        res = {1'b1, idx[MAX_IDX_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pkt_rr_picker.sv
// Combinational rotating priority encoder: first requester after 'last', wrapping.
module pkt_rr_picker
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              gnt_vld,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [MAX_IN-1:0]    req_ext;
  logic [MAX_IDX_W-1:0] last_ext;
  logic [MAX_IDX_W:0]   res;

  always_comb begin
    req_ext  = MAX_IN'(req);
    last_ext = MAX_IDX_W'(last);
    res      = rr_next(req_ext, last_ext, NUM_IN);
  end

  assign gnt_vld = res[MAX_IDX_W];
  assign gnt_idx = IDX_W'(res[MAX_IDX_W-1:0]);

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_IN Avalon-ST streams into one FIFO input.
// Optional per-input packet and stall counters when PKT_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no packet in flight; SOP beats arbitrated each cycle, stray beats flushed
// LOCKED | mid-packet; output follows lock_idx until an EOP beat transfers
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter  int NUM_IN  = 4,
  parameter  int DATA_W  = 512,
  parameter  int EMPTY_W = EMPTY_W_DEF,
  localparam int IDX_W   = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  input  logic                      fifo_almost_full,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [NUM_IN-1:0]         proto_err,
  input  logic                      clr_err
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]      pkt_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  lock_idx, lock_idx_nxt;
  logic [IDX_W-1:0]  rr_last, rr_last_nxt;
  logic [NUM_IN-1:0] proto_err_nxt;
  logic [NUM_IN-1:0] err_set;

  logic              stall;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  sel;
  logic [NUM_IN-1:0] sel_oh;
  logic [NUM_IN-1:0] sop_req;
  logic [NUM_IN-1:0] stray;
  logic              fire;
  logic              cur_sop;
  logic              cur_eop;

  assign stall   = fifo_almost_full;
  assign sop_req = in_valid & in_startofpacket;
  assign stray   = in_valid & ~in_startofpacket;

  pkt_rr_picker #(.NUM_IN(NUM_IN)) u_picker (
    .req     (sop_req),
    .last    (rr_last),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  assign sel    = (state == LOCKED) ? lock_idx : (pick_vld ? pick_idx : '0);
  assign sel_oh = NUM_IN'(1) << sel;

  assign out_data          = in_data[int'(sel)*DATA_W +: DATA_W];
  assign out_empty         = in_empty[int'(sel)*EMPTY_W +: EMPTY_W];
  assign out_startofpacket = in_startofpacket[sel];
  assign out_endofpacket   = in_endofpacket[sel];
  assign cur_sop           = in_startofpacket[sel];
  assign cur_eop           = in_endofpacket[sel];

  // Handshake outputs are forced idle while rst_l is low so nothing is
  // consumed or presented during reset, even with live upstream traffic.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = '0;
    busy      = 1'b0;
    grant_idx = '0;
    if (rst_l) begin
      grant_idx = sel;
      if (state == LOCKED) begin
        busy      = 1'b1;
        out_valid = in_valid[lock_idx] & ~stall;
        in_ready  = sel_oh & {NUM_IN{out_ready & ~stall}};
      end else begin
        out_valid = pick_vld & ~stall;
        in_ready  = stray | (pick_vld ? (sel_oh & {NUM_IN{out_ready & ~stall}}) : '0);
      end
    end
  end

  assign fire = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    rr_last_nxt  = rr_last;
    err_set      = '0;
    case (state)
      IDLE: begin
        err_set = stray;
        if (fire) begin
          rr_last_nxt = pick_idx;
          if (!cur_eop) begin
            lock_idx_nxt = pick_idx;
            state_nxt    = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (fire && cur_sop) err_set = sel_oh;
        if (fire && cur_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new error in the same cycle as clr_err survives the clear.
    proto_err_nxt = (clr_err ? '0 : proto_err) | err_set;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      lock_idx  <= '0;
      rr_last   <= IDX_W'(NUM_IN - 1);
      proto_err <= '0;
    end else begin
      state     <= state_nxt;
      lock_idx  <= lock_idx_nxt;
      rr_last   <= rr_last_nxt;
      proto_err <= proto_err_nxt;
    end
  end

`ifdef PKT_ARB_STATS_EN
  logic grant_pending;

  assign grant_pending = (state == LOCKED) ? in_valid[lock_idx] : pick_vld;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire && cur_eop) begin
        pkt_cnt[int'(sel)*32 +: 32] <= pkt_cnt[int'(sel)*32 +: 32] + 32'd1;
      end
      if (grant_pending && stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: combinational vector table plus packet sequences.
module tb_pkt_rr_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 32;
  localparam int EW  = 6;

  logic            clk;
  logic            rst_l;
  logic [NUM*DW-1:0] in_data;
  logic [NUM-1:0]  in_valid;
  logic [NUM-1:0]  in_ready;
  logic [NUM-1:0]  in_sop;
  logic [NUM-1:0]  in_eop;
  logic [NUM*EW-1:0] in_empty;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_sop;
  logic            out_eop;
  logic [EW-1:0]   out_empty;
  logic            af;
  logic            busy;
  logic [1:0]      grant_idx;
  logic [NUM-1:0]  proto_err;
  logic            clr_err;
`ifdef PKT_ARB_STATS_EN
  logic [NUM*32-1:0] pkt_cnt;
  logic [31:0]       stall_cnt;
`endif

  pkt_rr_arbiter #(.NUM_IN(NUM), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty),
    .fifo_almost_full  (af),
    .busy              (busy),
    .grant_idx         (grant_idx),
    .proto_err         (proto_err),
    .clr_err           (clr_err)
`ifdef PKT_ARB_STATS_EN
    ,
    .pkt_cnt           (pkt_cnt),
    .stall_cnt         (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int i, input int p, input int b);
    return {8'h00, 8'(i), 8'(p), 8'(b)};
  endfunction

  // Queue-driven sources and an output sink
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       srcq [NUM][$];
  logic [31:0] sink_data [$];
  logic [1:0]  sink_gnt [$];
  int          sink_cyc [$];
  logic        src_en = 1'b0;
  logic [NUM-1:0] pop_mask;

  task automatic present();
    for (int i = 0; i < NUM; i++) begin
      if (srcq[i].size() > 0) begin
        in_valid[i]           = 1'b1;
        in_sop[i]             = srcq[i][0].sop;
        in_eop[i]             = srcq[i][0].eop;
        in_data[i*DW +: DW]   = srcq[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
        in_sop[i]   = 1'b0;
        in_eop[i]   = 1'b0;
      end
    end
  endtask

  always begin
    @(negedge clk);
    pop_mask = '0;
    if (src_en && rst_l) begin
      pop_mask = in_valid & in_ready;
      if (out_valid && out_ready) begin
        sink_data.push_back(out_data);
        sink_gnt.push_back(grant_idx);
        sink_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    if (src_en) begin
      for (int i = 0; i < NUM; i++)
        if (pop_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      present();
    end
  end

  task automatic push_pkt(input int i, input int p, input int n);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.data = mk(i, p, b);
      bt.sop  = (b == 0);
      bt.eop  = (b == n - 1);
      srcq[i].push_back(bt);
    end
  endtask

  task automatic push_beat(input int i, input int p, input int b, input logic s, input logic e);
    beat_t bt;
    bt.data = mk(i, p, b);
    bt.sop  = s;
    bt.eop  = e;
    srcq[i].push_back(bt);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM; i++) srcq[i].delete();
    sink_data.delete();
    sink_gnt.delete();
    sink_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_l = 1'b0;
    clear_all();
    af      = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
  endtask

  task automatic wait_sink(input int n, input int budget, input string name);
    int k = 0;
    while (sink_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, " beat count"}, sink_data.size(), n);
  endtask

  task automatic wait_fires(input int n, input int budget, input string name);
    int seen = 0;
    int k    = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      if (out_valid && out_ready) seen++;
      k++;
    end
    chk({name, " fires"}, seen, n);
  endtask

  // Combinational IDLE vectors, rr_last = 3 after reset so priority is 0,1,2,3
  typedef struct {
    logic [3:0]  vin;
    logic [3:0]  sop;
    logic        ordy;
    logic        af;
    logic        ov;
    logic [1:0]  gi;
    logic [3:0]  ir;
    logic [31:0] dat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 32'h0000_0900};
    tbl[2] = '{4'b1100, 4'b1100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 32'h0002_0900};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 32'h0003_0900};
    tbl[4] = '{4'b1010, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 32'h0};
    tbl[5] = '{4'b0110, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0001_0900};
    tbl[6] = '{4'b1001, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1001, 32'h0000_0900};
    tbl[7] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0100, 32'h0};
    tbl[8] = '{4'b0011, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 32'h0001_0900};
    tbl[9] = '{4'b1110, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2, 4'b1010, 32'h0};

    rst_l     = 1'b0;
    out_ready = 1'b1;
    af        = 1'b0;
    clr_err   = 1'b0;
    in_eop    = '0;
    in_empty  = {6'd3, 6'd2, 6'd1, 6'd0};
    for (int i = 0; i < NUM; i++) in_data[i*DW +: DW] = mk(i, 9, 0);
    in_valid  = 4'b1111;
    in_sop    = 4'b0000;

    // Reset with live stray traffic: outputs must stay idle
    #3;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset grant_idx", grant_idx, 0);
    chk("reset proto_err", proto_err, 0);
    in_valid = '0;
    @(posedge clk);
    #2 rst_l = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid  = tbl[k].vin;
      in_sop    = tbl[k].sop;
      out_ready = tbl[k].ordy;
      af        = tbl[k].af;
      #1;
      chk($sformatf("vec%0d out_valid", k), out_valid, tbl[k].ov);
      chk($sformatf("vec%0d grant_idx", k), grant_idx, tbl[k].gi);
      chk($sformatf("vec%0d in_ready", k), in_ready, tbl[k].ir);
      chk($sformatf("vec%0d busy", k), busy, 0);
      if (tbl[k].ov) begin
        chk($sformatf("vec%0d out_data", k), out_data, tbl[k].dat);
        chk($sformatf("vec%0d out_empty", k), out_empty, 32'(tbl[k].gi));
      end
      #1;
      in_valid  = '0;
      in_sop    = '0;
      out_ready = 1'b1;
      af        = 1'b0;
    end

    src_en = 1'b1;

    // Two 3-beat packets on inputs 0 and 2: no interleave, then rr_last = 2
    do_reset();
    push_pkt(0, 0, 3);
    push_pkt(2, 0, 3);
    wait_sink(6, 40, "seqA");
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("seqA data%0d", k), sink_data[k], mk((k < 3) ? 0 : 2, 0, k % 3));
      chk($sformatf("seqA gnt%0d", k), sink_gnt[k], (k < 3) ? 0 : 2);
    end
    push_pkt(0, 1, 1);
    push_pkt(3, 1, 1);
    wait_sink(8, 20, "seqA rr");
    chk("seqA rr first", sink_gnt[6], 3);
    chk("seqA rr second", sink_gnt[7], 0);

    // Continuous single-beat packets on all inputs
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NUM; i++) push_pkt(i, p, 1);
    wait_sink(12, 60, "seqB");
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("seqB gnt%0d", k), sink_gnt[k], k % 4);
      chk($sformatf("seqB data%0d", k), sink_data[k], mk(k % 4, k / 4, 0));
    end
    chk("seqB back-to-back", sink_cyc[11] - sink_cyc[0], 11);

    // Almost-full stall for 5 cycles mid-packet on input 1
    do_reset();
    push_pkt(1, 0, 5);
    wait_fires(2, 20, "seqC");
    @(posedge clk);
    #2 af = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("seqC stall out_valid", out_valid, 0);
      chk("seqC stall in_ready", in_ready, 0);
      chk("seqC stall busy", busy, 1);
      chk("seqC stall grant_idx", grant_idx, 1);
    end
    @(posedge clk);
    #2 af = 1'b0;
    wait_sink(5, 30, "seqC");
    for (int k = 0; k < 5; k++)
      chk($sformatf("seqC data%0d", k), sink_data[k], mk(1, 0, k));

    // Stray beat on input 3 while IDLE, clear, set-wins, SOP inside packet
    do_reset();
    push_beat(3, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("seqD stray in_ready", in_ready, 4'b1000);
    chk("seqD stray out_valid", out_valid, 0);
    @(posedge clk);
    #3;
    chk("seqD proto_err set", proto_err, 4'b1000);
    chk("seqD stray not forwarded", sink_data.size(), 0);
    clr_err = 1'b1;
    @(posedge clk);
    #3 clr_err = 1'b0;
    chk("seqD proto_err cleared", proto_err, 4'b0000);
    push_beat(1, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #3 clr_err = 1'b0;
    chk("seqD set wins over clear", proto_err, 4'b0010);
    clr_err = 1'b1;
    @(posedge clk);
    #3 clr_err = 1'b0;
    push_beat(0, 0, 0, 1'b1, 1'b0);
    push_beat(0, 0, 1, 1'b1, 1'b0);
    push_beat(0, 0, 2, 1'b0, 1'b1);
    wait_sink(3, 20, "seqD locked sop");
    @(posedge clk);
    #3;
    chk("seqD locked sop proto_err", proto_err, 4'b0001);
    chk("seqD locked sop busy", busy, 0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("seqD data%0d", k), sink_data[k], mk(0, 0, k));

    // Reset while locked on input 2
    do_reset();
    push_pkt(2, 0, 6);
    wait_fires(2, 20, "seqE");
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("seqE rst out_valid", out_valid, 0);
    chk("seqE rst busy", busy, 0);
    chk("seqE rst in_ready", in_ready, 0);
    chk("seqE rst grant_idx", grant_idx, 0);
    clear_all();
    @(negedge clk);
    push_pkt(0, 1, 1);
    push_pkt(2, 1, 1);
    push_pkt(3, 1, 1);
    @(posedge clk);
    #2 rst_l = 1'b1;
    @(negedge clk);
    chk("seqE first grant", grant_idx, 0);
    chk("seqE first valid", out_valid, 1);
    wait_sink(3, 20, "seqE");
    chk("seqE order0", sink_gnt[0], 0);
    chk("seqE order1", sink_gnt[1], 2);
    chk("seqE order2", sink_gnt[2], 3);

`ifdef PKT_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 10; p++) push_pkt(1, p, 2);
    wait_sink(20, 80, "stats");
    @(posedge clk);
    #3;
    chk("stats pkt_cnt0", pkt_cnt[0 +: 32], 0);
    chk("stats pkt_cnt1", pkt_cnt[32 +: 32], 10);
    chk("stats pkt_cnt2", pkt_cnt[64 +: 32], 0);
    chk("stats pkt_cnt3", pkt_cnt[96 +: 32], 0);
    chk("stats stall_cnt", stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
